link_tx_arb: RTL and testbench
==============================

# link_tx_arb

Round-robin arbiter that shares the single link transmit buffer and `tx_start` strobe between two frame producers on a control-station card: channel 0 (bus response path, tx_bus) and channel 1 (card status/diagnostic frames). It sits between the producers and the link interface, and grants the buffer to one producer at a time. It forwards that producer's buffer writes and start strobe, holds the grant until the link reports completion, and releases with timeout protection.

## Interface
Parameters:
- `AW`, 11: tx buffer address and length width.
- `TO_CYC`, 16'd50000: timeout, in clk cycles, for both the GRANT and SEND phases.

Ports:
- `clk` in 1: single clock; every register is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req0`, `req1` in 1 each: level request, held until grant is released.
- `gnt0`, `gnt1` out 1 each: grant level; at most one is high.
- `ch0_wren`, `ch1_wren` in 1 each: buffer write strobe; honoured only while the channel is granted.
- `ch0_waddr`, `ch1_waddr` in AW each: buffer write address.
- `ch0_wdata`, `ch1_wdata` in 8 each: buffer write data.
- `ch0_len`, `ch1_len` in AW each: frame length in bytes; sampled with start.
- `ch0_start`, `ch1_start` in 1 each: 1-cycle pulse meaning the frame is fully written.
- `tx_done` in 1: 1-cycle pulse from the link when transmission completes.
- `tx_buf_wren` out 1, `tx_buf_waddr` out AW, `tx_buf_wdata` out 8: registered buffer write port.
- `tx_data_len` out AW: frame length; held stable from start until release.
- `tx_start` out 1: 1-cycle pulse to the link.
- `timeout_err` out 1: 1-cycle pulse when a phase is aborted by timeout.

## Operation
- States: IDLE, GRANT, SEND, REL.
- **IDLE**
  - Neither request pending: stay in IDLE.
  - One request pending: grant that channel.
  - Both pending: grant the channel that is not `last`. `last` resets to 1, so ch0 wins the first tie.
  - On entering GRANT: set the `gntN` register, set `last` = N, clear the timer.
- **GRANT**
  - Granted channel's wren/waddr/wdata are registered onto `tx_buf_*`.
  - The non-granted channel's strobes are ignored.
  - `chN_start` with `chN_len` != 0: latch the length into `tx_data_len`, pulse `tx_start`, go to SEND.
  - `chN_start` with `chN_len` == 0: abandon and go to REL; no `tx_start`.
  - `reqN` dropped before start: abandon and go to REL.
  - Timer reaches `TO_CYC`-1: pulse `timeout_err`, go to REL.
- **SEND**
  - All `ch*_wren` inputs are ignored and `tx_buf_wren` = 0.
  - `tx_done`: go to REL.
  - Timer reaches `TO_CYC`-1: pulse `timeout_err`, go to REL.
  - Dropping `reqN` in SEND does not abort.
- **REL**
  - Clear `gntN` and `tx_data_len`, then go to IDLE.
  - This gives one dead cycle between grants.
- **Ignored inputs:**
  - `tx_done` outside SEND.
  - `start` from the non-granted channel.
  - Repeated `start` in SEND.
- **Timer:** 16-bit, increments every cycle in GRANT/SEND, cleared on every state change, saturates (never wraps).

## Timing
- **Reset values:** all outputs 0, state IDLE, `last` = 1, timer 0.
- **Reset assertion mid-frame:**
  - Immediately drops the grant and `tx_start`.
  - No `timeout_err` is issued.
- **Grant latency:**
  - `req` sampled high in IDLE → `gnt` high the next cycle (1 clk).
- **Write path latency:** `chN_wren` at cycle t → `tx_buf_wren`/addr/data at t+1.
- **Start latency:**
  - `chN_start` at t → `tx_start` and `tx_data_len` valid at t+1.
  - The last write issued at t therefore lands no later than `tx_start`.
  - A write and start in the same cycle are both forwarded.
- **Release:**
  - `tx_done` at t → state REL at t+1, `gnt` low at t+2.
  - The next grant is asserted at t+3 at the earliest.
- **Timeout:**
  - `timeout_err` pulses in the cycle state changes to REL.
  - This is `TO_CYC` cycles after entering the phase.
- **Simultaneous events:**
  - `tx_done` and timeout in the same cycle: `tx_done` wins, no `timeout_err`.
  - `req` drop and `start` in the same cycle: `start` wins, and the frame is sent.

## Test plan
- **Single channel:** `req0` only; 4 writes (addr 0..3, data A5,5A,FF,00); `start` with len=4.
  - `gnt0` at +1.
  - `tx_buf` writes mirror the input with 1-cycle delay.
  - `tx_start` pulse with `tx_data_len`=4.
  - `tx_done` → `gnt0` low 2 cycles later.
- **Contention:** `req0` and `req1` high together from reset.
  - Order ch0, ch1, ch0 across three frames.
  - `gnt0`&`gnt1` is never high at the same time.
  - ch1 writes during ch0's grant never reach `tx_buf`.
- **Timeout:** `TO_CYC`=16.
  - Withhold `tx_done` → `timeout_err` 16 cycles after `tx_start`, grant released.
  - Withhold `start` → same behaviour in GRANT, and no `tx_start`.
- **Abandon:**
  - `req1` dropped in GRANT → no `tx_start`, `gnt1` low within 2 cycles.
  - `start` with len=0 → no `tx_start`.
- **Edge collisions:**
  - `tx_done` and timeout in the same cycle → no `timeout_err`.
  - Write and `start` in the same cycle → write forwarded, then `tx_start`.
- **Reset:** `reset` low in SEND.
  - All outputs 0 asynchronously.
  - After release, ch0 is granted first on a tie.

Source files
------------

// File: rtl/link_tx_arb.sv
// rtl/link_tx_arb.sv - two-channel round-robin arbiter for the link transmit buffer
module link_tx_arb #(
    parameter int unsigned AW     = 11,
    parameter logic [15:0] TO_CYC = 16'd50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    output logic          gnt0,
    output logic          gnt1,
    input  logic          ch0_wren,
    input  logic          ch1_wren,
    input  logic [AW-1:0] ch0_waddr,
    input  logic [AW-1:0] ch1_waddr,
    input  logic [7:0]    ch0_wdata,
    input  logic [7:0]    ch1_wdata,
    input  logic [AW-1:0] ch0_len,
    input  logic [AW-1:0] ch1_len,
    input  logic          ch0_start,
    input  logic          ch1_start,
    input  logic          tx_done,
    output logic          tx_buf_wren,
    output logic [AW-1:0] tx_buf_waddr,
    output logic [7:0]    tx_buf_wdata,
    output logic [AW-1:0] tx_data_len,
    output logic          tx_start,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SEND  = 2'd2,
        S_REL   = 2'd3
    } state_t;

    state_t        state_q;
    logic          last_q;
    logic [15:0]   timer_q;
    logic [15:0]   timer_d;
    logic          timer_hit;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          wren_q;
    logic [AW-1:0] waddr_q;
    logic [7:0]    wdata_q;
    logic [AW-1:0] len_q;
    logic          start_q;
    logic          to_q;

    // last_q doubles as the owner select: it is set to the granted channel on entry to GRANT
    logic          sel_req;
    logic          sel_wren;
    logic [AW-1:0] sel_waddr;
    logic [7:0]    sel_wdata;
    logic [AW-1:0] sel_len;
    logic          sel_start;

    // Route the owning channel's inputs and compute the saturating phase timer
    always_comb begin
        sel_req   = last_q ? req1      : req0;
        sel_wren  = last_q ? ch1_wren  : ch0_wren;
        sel_waddr = last_q ? ch1_waddr : ch0_waddr;
        sel_wdata = last_q ? ch1_wdata : ch0_wdata;
        sel_len   = last_q ? ch1_len   : ch0_len;
        sel_start = last_q ? ch1_start : ch0_start;
        timer_d   = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        timer_hit = (timer_q == TO_CYC - 16'd1);
    end

    // Arbitration FSM with registered grant, buffer write, start and timeout outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            timer_q <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            to_q    <= 1'b0;
            wren_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (req0 && (!req1 || last_q)) begin
                        gnt0_q  <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= S_GRANT;
                    end else if (req1) begin
                        gnt1_q  <= 1'b1;
                        last_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    wren_q <= sel_wren;
                    if (sel_wren) begin
                        waddr_q <= sel_waddr;
                        wdata_q <= sel_wdata;
                    end
                    timer_q <= timer_d;
                    // start outranks a same-cycle request drop so the frame is still sent
                    if (sel_start && (sel_len != '0)) begin
                        len_q   <= sel_len;
                        start_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_SEND;
                    end else if (sel_start || !sel_req) begin
                        timer_q <= '0;
                        state_q <= S_REL;
                    end else if (timer_hit) begin
                        to_q    <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_REL;
                    end
                end
                S_SEND: begin
                    timer_q <= timer_d;
                    // completion outranks a coinciding timeout
                    if (tx_done) begin
                        timer_q <= '0;
                        state_q <= S_REL;
                    end else if (timer_hit) begin
                        to_q    <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_REL;
                    end
                end
                S_REL: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    len_q   <= '0;
                    timer_q <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign tx_buf_wren  = wren_q;
    assign tx_buf_waddr = waddr_q;
    assign tx_buf_wdata = wdata_q;
    assign tx_data_len  = len_q;
    assign tx_start     = start_q;
    assign timeout_err  = to_q;

endmodule

// File: tb/tb_link_tx_arb.sv
// tb/tb_link_tx_arb.sv - directed and randomized frame-level bench for link_tx_arb
module tb_link_tx_arb;

    localparam int TO = 16;
    localparam int K_DONE     = 0;
    localparam int K_SEND_TO  = 1;
    localparam int K_GRANT_TO = 2;
    localparam int K_DROP     = 3;
    localparam int K_LEN0     = 4;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        ch0_wren, ch1_wren;
    logic [10:0] ch0_waddr, ch1_waddr;
    logic [7:0]  ch0_wdata, ch1_wdata;
    logic [10:0] ch0_len, ch1_len;
    logic        ch0_start, ch1_start;
    logic        tx_done;
    logic        tx_buf_wren;
    logic [10:0] tx_buf_waddr;
    logic [7:0]  tx_buf_wdata;
    logic [10:0] tx_data_len;
    logic        tx_start;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int m_last = 1;

    logic        e_gnt0, e_gnt1, e_wren, e_start, e_to;
    logic [10:0] e_waddr, e_len;
    logic [7:0]  e_wdata;

    logic [10:0] f_addr [8];
    logic [7:0]  f_data [8];

    link_tx_arb #(.AW(11), .TO_CYC(16'd16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .ch0_wren(ch0_wren), .ch1_wren(ch1_wren),
        .ch0_waddr(ch0_waddr), .ch1_waddr(ch1_waddr),
        .ch0_wdata(ch0_wdata), .ch1_wdata(ch1_wdata),
        .ch0_len(ch0_len), .ch1_len(ch1_len),
        .ch0_start(ch0_start), .ch1_start(ch1_start),
        .tx_done(tx_done),
        .tx_buf_wren(tx_buf_wren), .tx_buf_waddr(tx_buf_waddr), .tx_buf_wdata(tx_buf_wdata),
        .tx_data_len(tx_data_len), .tx_start(tx_start), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // grants must never overlap, checked continuously away from the rising edge
    always @(negedge clk) begin
        if (reset) begin
            n_vec++;
            assert (!(gnt0 && gnt1)) else begin
                n_err++;
                $error("FAIL gnt_exclusive observed=%0b%0b expected=not both", gnt0, gnt1);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(e_gnt0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(e_gnt1));
        chk({tag, ".wren"}, 32'(tx_buf_wren), 32'(e_wren));
        if (e_wren) begin
            chk({tag, ".waddr"}, 32'(tx_buf_waddr), 32'(e_waddr));
            chk({tag, ".wdata"}, 32'(tx_buf_wdata), 32'(e_wdata));
        end
        chk({tag, ".len"}, 32'(tx_data_len), 32'(e_len));
        chk({tag, ".start"}, 32'(tx_start), 32'(e_start));
        chk({tag, ".timeout"}, 32'(timeout_err), 32'(e_to));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic exp_all_zero();
        e_gnt0 = 0; e_gnt1 = 0; e_wren = 0; e_start = 0; e_to = 0;
        e_waddr = '0; e_wdata = '0; e_len = '0;
    endtask

    task automatic clear_strobes();
        ch0_wren = 0; ch1_wren = 0; ch0_waddr = '0; ch1_waddr = '0;
        ch0_wdata = '0; ch1_wdata = '0; ch0_len = '0; ch1_len = '0;
        ch0_start = 0; ch1_start = 0; tx_done = 0;
    endtask

    task automatic drive_wr(input int ch, input logic [10:0] a, input logic [7:0] d);
        if (ch == 0) begin ch0_wren = 1; ch0_waddr = a; ch0_wdata = d; end
        else begin ch1_wren = 1; ch1_waddr = a; ch1_wdata = d; end
    endtask

    task automatic drive_start(input int ch, input logic [10:0] l);
        if (ch == 0) begin ch0_start = 1; ch0_len = l; end
        else begin ch1_start = 1; ch1_len = l; end
    endtask

    task automatic set_req(input int ch, input logic v);
        if (ch == 0) req0 = v; else req1 = v;
    endtask

    task automatic rand_fill();
        for (int i = 0; i < 8; i++) begin
            f_addr[i] = 11'($urandom);
            f_data[i] = 8'($urandom);
        end
    endtask

    // One whole frame from IDLE back to IDLE; expectations follow the arbitration
    // and timing rules: grant next cycle, writes echoed one cycle later, start
    // echoed one cycle later, grant dropped one cycle after entering release.
    task automatic frame(input int mask, input int kind, input int nwr, input logic [10:0] len,
                         input int dly, input bit same, input bit noise);
        int w, o, g_end, s_end;
        bit wr;
        if (mask == 3) w = (m_last == 1) ? 0 : 1;
        else w = (mask == 1) ? 0 : 1;
        o = 1 - w;
        m_last = w;

        clear_strobes();
        req0 = mask[0];
        req1 = mask[1];
        exp_all_zero();
        e_gnt0 = (w == 0);
        e_gnt1 = (w == 1);
        tick("grant");

        if (kind == K_GRANT_TO) g_end = TO - 1;
        else if (same && kind != K_DROP) g_end = nwr - 1;
        else g_end = nwr;

        for (int g = 0; g <= g_end; g++) begin
            clear_strobes();
            wr = (g < nwr);
            e_wren = wr;
            if (wr) begin
                drive_wr(w, f_addr[g], f_data[g]);
                e_waddr = f_addr[g];
                e_wdata = f_data[g];
            end
            if (noise) begin
                drive_wr(o, 11'($urandom), 8'($urandom));
                drive_start(o, 11'($urandom_range(0, 2047)));
            end
            if (g != g_end) tx_done = 1'($urandom_range(0, 1));
            if (g == g_end) begin
                case (kind)
                    K_DONE, K_SEND_TO: begin
                        drive_start(w, len);
                        if ($urandom_range(0, 1) == 1) set_req(w, 1'b0);
                        e_start = 1;
                        e_len = len;
                    end
                    K_DROP:  set_req(w, 1'b0);
                    K_LEN0:  drive_start(w, 11'd0);
                    default: e_to = 1;
                endcase
            end
            tick("grant_phase");
            e_start = 0;
        end

        if (kind == K_DONE || kind == K_SEND_TO) begin
            s_end = (kind == K_SEND_TO) ? TO - 1 : dly;
            for (int s = 0; s <= s_end; s++) begin
                clear_strobes();
                if ($urandom_range(0, 1) == 1) drive_wr(w, 11'($urandom), 8'($urandom));
                if ($urandom_range(0, 1) == 1) drive_start(w, 11'($urandom_range(1, 2047)));
                if (noise) drive_wr(o, 11'($urandom), 8'($urandom));
                set_req(w, 1'($urandom_range(0, 1)));
                e_wren = 0;
                e_start = 0;
                if (s == s_end) begin
                    if (kind == K_DONE) tx_done = 1;
                    e_to = (kind == K_SEND_TO);
                end
                tick("send_phase");
            end
        end

        clear_strobes();
        req0 = 0;
        req1 = 0;
        exp_all_zero();
        tick("release");
    endtask

    initial begin
        int mask, kind, nwr;
        reset = 1;
        req0 = 0;
        req1 = 0;
        clear_strobes();
        exp_all_zero();
        #3 reset = 0;
        #1 check_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 check_outputs("reset_hold");
        reset = 1;

        // contention from reset: ch0, ch1, ch0 with the loser writing noise
        for (int i = 0; i < 3; i++) begin
            rand_fill();
            frame(3, K_DONE, 3, 11'($urandom_range(1, 2047)), 2, 0, 1);
        end

        // single channel, fixed pattern
        f_addr[0] = 11'd0; f_data[0] = 8'hA5;
        f_addr[1] = 11'd1; f_data[1] = 8'h5A;
        f_addr[2] = 11'd2; f_data[2] = 8'hFF;
        f_addr[3] = 11'd3; f_data[3] = 8'h00;
        frame(1, K_DONE, 4, 11'd4, 3, 0, 0);

        // timeouts in SEND and in GRANT
        rand_fill();
        frame(1, K_SEND_TO, 2, 11'd100, 0, 0, 1);
        rand_fill();
        frame(2, K_GRANT_TO, 3, 11'd0, 0, 0, 1);

        // abandons
        rand_fill();
        frame(2, K_DROP, 2, 11'd0, 0, 0, 1);
        rand_fill();
        frame(1, K_LEN0, 1, 11'd0, 0, 0, 0);

        // edge collisions: done on the timeout cycle, write with start
        rand_fill();
        frame(1, K_DONE, 2, 11'd2047, TO - 1, 0, 0);
        rand_fill();
        frame(2, K_DONE, 3, 11'd7, 1, 1, 1);

        // randomized frames
        for (int i = 0; i < 24; i++) begin
            rand_fill();
            mask = $urandom_range(1, 3);
            kind = $urandom_range(0, 4);
            nwr  = $urandom_range(1, 5);
            frame(mask, kind, nwr, 11'($urandom_range(1, 2047)), $urandom_range(0, TO - 1),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset while in SEND on a ch0 frame, so a plain tie would go to ch1 next
        clear_strobes();
        req0 = 1;
        req1 = 0;
        m_last = 0;
        exp_all_zero();
        e_gnt0 = 1;
        tick("rst_grant");
        ch0_start = 1;
        ch0_len = 11'd5;
        e_start = 1;
        e_len = 11'd5;
        tick("rst_start");
        clear_strobes();
        #2 reset = 0;
        #1;
        exp_all_zero();
        check_outputs("rst_mid_send");
        @(posedge clk);
        #1 check_outputs("rst_mid_hold");
        req0 = 0;
        reset = 1;
        m_last = 1;
        rand_fill();
        frame(3, K_DONE, 2, 11'd9, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
